dmem_port_scheduler: RTL and testbench
======================================

Name: dmem_port_scheduler

Overview:
- Sequences the single data-memory port between two requesters.
- Speculative loads arrive from the load/store unit; committed stores arrive from the ROB at retirement.
- Committed stores are buffered in a small in-order queue and drained when the port is free, or when forced by fullness or starvation.
- A load is held back while an older store to the same address is still buffered, so loads always see committed data. Sits between the LS unit/ROB and the data memory array.

Parameters:
- SQ_DEPTH, 4, committed-store queue entries (power of 2, >=2)
- TAG_W, 6, load tag width (ROB index)
- STARVE_LIMIT, 8, consecutive cycles a non-empty queue may go undrained before a store is forced

Ports:
- clk  in  1  clock
- reset  in  1  reset
- ld_req_valid  in  1  load request valid
- ld_req_ready  out  1  load granted this cycle
- ld_req_addr  in  32  load address (word index into memory)
- ld_req_funct3  in  3  LB/LH/LW/LBU/LHU encoding
- ld_req_tag  in  TAG_W  load ROB tag
- st_commit_valid  in  1  ROB commits a store
- st_commit_ready  out  1  store queue can accept
- st_commit_addr  in  32  store address
- st_commit_funct3  in  3  SB/SH/SW encoding
- st_commit_data  in  32  store data
- flush  in  1  pipeline flush (mispredict/exception)
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_addr  out  32  memory address
- mem_funct3  out  3  access size/sign
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_re
- ld_resp_valid  out  1  load data returned
- ld_resp_tag  out  TAG_W  tag of returned load
- ld_resp_data  out  32  load data
- sq_empty  out  1  store queue empty (fence/drain indication)

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is clk. On reset the queue is emptied, the starvation counter is 0, every output is 0 and sq_empty is 1.
- Store queue:
  - FIFO of {addr, funct3, data}.
  - st_commit_ready = (count < SQ_DEPTH). This is independent of a same-cycle pop, so there is no comb path from the arbiter.
  - Push when st_commit_valid && st_commit_ready. Push and pop in the same cycle is allowed and count is unchanged.
  - Pointers wrap modulo SQ_DEPTH.
- Load hazard:
  - hazard = ld_req_addr equals the addr of any valid queue entry, OR (st_commit_valid && st_commit_addr == ld_req_addr).
  - The compare is exact 32-bit.
  - A committed store is always older than any pending load.
- Per-cycle arbitration (one port op per cycle, combinational grant):
  - force_st = count>0 && (count==SQ_DEPTH || starve_cnt>=STARVE_LIMIT).
  - load_ok = ld_req_valid && !hazard && !flush.
  - If force_st, drain the head store.
  - Else if load_ok, grant the load (ld_req_ready=1).
  - Else if count>0, drain the head store.
  - Else idle.
- Port drive:
  - Store drain: mem_we=1, mem_addr/mem_funct3/mem_wdata = head entry, pop.
  - Load grant: mem_re=1, mem_addr/mem_funct3 = request.
  - Idle: mem_we=mem_re=0, other mem_* = 0.
  - mem_we and mem_re are never both 1.
- Starvation counter:
  - Increments each cycle count>0 and no store is drained.
  - Clears on any drain or when the queue is empty.
  - Saturates at STARVE_LIMIT.
- Load response:
  - Register grant and tag; next cycle ld_resp_valid=1, ld_resp_tag = registered tag, ld_resp_data = mem_rdata. Latency is exactly 1.
  - If flush is high in the response cycle, ld_resp_valid is suppressed (0).
  - No load is granted in a flush cycle.
- Flush never discards queued stores; they are architecturally committed.
- sq_empty = (count==0), registered-state based.
- Reset mid-drain: queued stores are lost and no memory write occurs in the reset cycle.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - sq_entry_t struct {addr[31:0], funct3[2:0], data[31:0]}.
- One sub-module, dmem_store_queue. It owns the FIFO storage, pointers and count, exposes head entry and full/empty, and provides a parallel address-match output for the hazard check.
- Arbiter, starvation counter and response register live in the top.

Test Plan:
- Load only, empty queue: ld_req addr=0x10, LW, tag=5 -> same cycle mem_re=1, mem_addr=0x10. Next cycle ld_resp_valid=1, tag=5, data=mem_rdata.
- Hazard: commit SW addr=0x20 data=0xDEADBEEF, then a load to 0x20 in the next cycle -> load held (ready=0) until mem_we to 0x20 occurs. Load granted the cycle after, and returns 0xDEADBEEF from the memory model.
- Same-cycle hazard: st_commit to 0x30 and ld_req to 0x30 in the same cycle -> ld_req_ready=0 that cycle.
- Full queue: 4 stores committed while a load stream to distinct addresses is continuously valid -> when count=4, store drains (mem_we=1), st_commit_ready=0 only while count=4.
- Starvation: 1 store queued plus continuous non-hazard loads -> after 8 load grants a forced mem_we. Counter restarts at 0.
- Flush: load granted at cycle t, flush at t+1 -> ld_resp_valid=0. Queued stores still drain and sq_empty rises after the last mem_we.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port scheduler.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  funct3;
      logic [31:0] data;
   } sq_entry_t;

endpackage

// File: rtl/dmem_store_queue.sv
// In-order committed-store FIFO with a parallel address match over live entries.
module dmem_store_queue
   import dmem_pkg::*;
#(
   parameter int SQ_DEPTH = 4,
   localparam int PTR_W = $clog2(SQ_DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  sq_entry_t        push_entry_i,
   input  logic             pop_i,
   input  logic [31:0]      match_addr_i,
   output sq_entry_t        head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             match_o
);

   sq_entry_t        mem_q [SQ_DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q, count_d;

   // Occupancy next-state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers and count; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + PTR_W'(1);
         if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset: liveness is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= push_entry_i;
   end

   // An entry is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PTR_W-1:0] offs;
      match_o = 1'b0;
      offs    = '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         offs = PTR_W'(i) - rptr_q;
         if (({1'b0, offs} < count_q) && (mem_q[i].addr == match_addr_i))
            match_o = 1'b1;
      end
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(SQ_DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/dmem_port_scheduler.sv
// Arbitrates the single data-memory port between speculative loads and
// buffered committed stores, with forced draining on fullness or starvation.
module dmem_port_scheduler
   import dmem_pkg::*;
#(
   parameter int SQ_DEPTH     = 4,
   parameter int TAG_W        = 6,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_req_valid,
   output logic             ld_req_ready,
   input  logic [31:0]      ld_req_addr,
   input  logic [2:0]       ld_req_funct3,
   input  logic [TAG_W-1:0] ld_req_tag,
   input  logic             st_commit_valid,
   output logic             st_commit_ready,
   input  logic [31:0]      st_commit_addr,
   input  logic [2:0]       st_commit_funct3,
   input  logic [31:0]      st_commit_data,
   input  logic             flush,
   output logic             mem_we,
   output logic             mem_re,
   output logic [31:0]      mem_addr,
   output logic [2:0]       mem_funct3,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic             ld_resp_valid,
   output logic [TAG_W-1:0] ld_resp_tag,
   output logic [31:0]      ld_resp_data,
   output logic             sq_empty
);

   localparam int CNT_W = $clog2(SQ_DEPTH) + 1;
   localparam int SW_W  = $clog2(STARVE_LIMIT + 1);

   sq_entry_t        head;
   sq_entry_t        push_entry;
   logic [CNT_W-1:0] sq_count;
   logic             sq_full, sq_match, push, drain, grant;
   logic             hazard, force_st, load_ok;
   logic [SW_W-1:0]  starve_q, starve_d;
   logic             resp_valid_q;
   logic [TAG_W-1:0] resp_tag_q;

   assign push_entry = '{addr: st_commit_addr, funct3: st_commit_funct3, data: st_commit_data};

   // Ready depends only on registered occupancy, keeping the arbiter off this path.
   assign st_commit_ready = !reset && !sq_full;
   assign push            = st_commit_valid && st_commit_ready;

   dmem_store_queue #(.SQ_DEPTH(SQ_DEPTH)) u_sq (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (drain),
      .match_addr_i (ld_req_addr),
      .head_o       (head),
      .count_o      (sq_count),
      .full_o       (sq_full),
      .empty_o      (sq_empty),
      .match_o      (sq_match)
   );

   // A same-cycle commit is older than the load, so it blocks it too.
   assign hazard   = sq_match || (st_commit_valid && (st_commit_addr == ld_req_addr));
   assign force_st = !sq_empty && (sq_full || (starve_q >= SW_W'(STARVE_LIMIT)));
   assign load_ok  = ld_req_valid && !hazard && !flush;

   // One port operation per cycle; reset suppresses all port activity.
   always_comb begin
      drain      = 1'b0;
      grant      = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = '0;
      mem_funct3 = '0;
      mem_wdata  = '0;
      if (!reset) begin
         if (force_st)       drain = 1'b1;
         else if (load_ok)   grant = 1'b1;
         else if (!sq_empty) drain = 1'b1;
      end
      if (drain) begin
         mem_we     = 1'b1;
         mem_addr   = head.addr;
         mem_funct3 = head.funct3;
         mem_wdata  = head.data;
      end else if (grant) begin
         mem_re     = 1'b1;
         mem_addr   = ld_req_addr;
         mem_funct3 = ld_req_funct3;
      end
   end

   assign ld_req_ready = grant;

   // Starvation count of undrained cycles with a non-empty queue, saturating.
   always_comb begin
      starve_d = starve_q;
      if (sq_empty || drain)                    starve_d = '0;
      else if (starve_q < SW_W'(STARVE_LIMIT)) starve_d = starve_q + SW_W'(1);
   end

   // Starvation and load-response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_tag_q   <= '0;
      end else begin
         starve_q     <= starve_d;
         resp_valid_q <= grant;
         if (grant) resp_tag_q <= ld_req_tag;
      end
   end

   assign ld_resp_valid = resp_valid_q && !flush && !reset;
   assign ld_resp_tag   = resp_tag_q;
   assign ld_resp_data  = ld_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Randomized bench for dmem_port_scheduler against a queue-based reference model.
module tb_dmem_port_scheduler;
   import dmem_pkg::*;

   localparam int TAG_W = 6;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             ld_req_valid, ld_req_ready;
   logic [31:0]      ld_req_addr;
   logic [2:0]       ld_req_funct3;
   logic [TAG_W-1:0] ld_req_tag;
   logic             st_commit_valid, st_commit_ready;
   logic [31:0]      st_commit_addr;
   logic [2:0]       st_commit_funct3;
   logic [31:0]      st_commit_data;
   logic             flush;
   logic             mem_we, mem_re;
   logic [31:0]      mem_addr;
   logic [2:0]       mem_funct3;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata = '0;
   logic             ld_resp_valid;
   logic [TAG_W-1:0] ld_resp_tag;
   logic [31:0]      ld_resp_data;
   logic             sq_empty;

   dmem_port_scheduler #(.SQ_DEPTH(DEPTH), .TAG_W(TAG_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
      .ld_req_funct3(ld_req_funct3), .ld_req_tag(ld_req_tag),
      .st_commit_valid(st_commit_valid), .st_commit_ready(st_commit_ready),
      .st_commit_addr(st_commit_addr), .st_commit_funct3(st_commit_funct3),
      .st_commit_data(st_commit_data), .flush(flush),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_funct3(mem_funct3),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data),
      .sq_empty(sq_empty)
   );

   always #5 clk = ~clk;

   // Memory array seen by the DUT; indexes alias on the low address bits.
   logic [31:0] env_mem [16] = '{default: 32'h0};
   always @(posedge clk) begin
      if (mem_we) env_mem[mem_addr[3:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= env_mem[mem_addr[3:0]];
   end

   int n_cmp = 0;
   int n_mis = 0;
   int n_forced = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference model state.
   sq_entry_t        mq[$];
   int               starve = 0;
   bit               pend = 0;
   logic [TAG_W-1:0] ptag = '0;
   logic [31:0]      pdata = '0;
   logic [31:0]      ref_mem [16] = '{default: 32'h0};
   bit               m_drain, m_grant;

   logic [2:0] f3s [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

   task automatic model_check();
      bit haz, frc, lok;
      int nq;
      logic [31:0] ea, ed;
      logic [2:0]  ef;
      nq  = mq.size();
      haz = 0;
      foreach (mq[i]) if (mq[i].addr == ld_req_addr) haz = 1;
      if (st_commit_valid && st_commit_addr == ld_req_addr) haz = 1;
      frc = (nq > 0) && (nq == DEPTH || starve >= LIMIT);
      lok = ld_req_valid && !haz && !flush;
      m_drain = 0; m_grant = 0;
      if (!reset) begin
         if (frc)          m_drain = 1;
         else if (lok)     m_grant = 1;
         else if (nq > 0)  m_drain = 1;
      end
      if (!reset && frc && ld_req_valid && !haz && !flush) n_forced++;
      ea = '0; ef = '0; ed = '0;
      if (m_drain) begin ea = mq[0].addr; ef = mq[0].funct3; ed = mq[0].data; end
      else if (m_grant) begin ea = ld_req_addr; ef = ld_req_funct3; end
      chk("ld_req_ready",    64'(ld_req_ready),    64'(m_grant));
      chk("st_commit_ready", 64'(st_commit_ready), 64'(!reset && nq < DEPTH));
      chk("mem_we",          64'(mem_we),          64'(m_drain));
      chk("mem_re",          64'(mem_re),          64'(m_grant));
      chk("mem_addr",        64'(mem_addr),        64'(ea));
      chk("mem_funct3",      64'(mem_funct3),      64'(ef));
      chk("mem_wdata",       64'(mem_wdata),       64'(ed));
      chk("ld_resp_valid",   64'(ld_resp_valid),   64'(pend && !flush && !reset));
      if (pend && !flush && !reset) begin
         chk("ld_resp_tag",  64'(ld_resp_tag),     64'(ptag));
         chk("ld_resp_data", 64'(ld_resp_data),    64'(pdata));
      end
      chk("sq_empty",        64'(sq_empty),        64'(nq == 0));
   endtask

   task automatic model_step();
      int was;
      if (reset) begin
         mq.delete();
         starve = 0;
         pend = 0;
         return;
      end
      was = mq.size();
      if (m_drain) begin
         ref_mem[mq[0].addr[3:0]] = mq[0].data;
         void'(mq.pop_front());
      end
      if (st_commit_valid && was < DEPTH)
         mq.push_back('{addr: st_commit_addr, funct3: st_commit_funct3, data: st_commit_data});
      if (was > 0 && !m_drain) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else                     starve = 0;
      pend = m_grant;
      if (m_grant) begin
         ptag  = ld_req_tag;
         pdata = ref_mem[ld_req_addr[3:0]];
      end
   endtask

   // Drive one cycle of inputs, check mid-cycle, advance the model at the edge.
   task automatic cycle(input int p_ld, input int p_st, input int p_fl, input bit ld_far, input int p_rst);
      #1;
      reset            = ($urandom_range(0, 99) < p_rst);
      ld_req_valid     = ($urandom_range(0, 99) < p_ld);
      ld_req_addr      = ld_far ? 32'h100 + $urandom_range(0, 15) : 32'($urandom_range(0, 7));
      ld_req_funct3    = f3s[$urandom_range(0, 4)];
      ld_req_tag       = TAG_W'($urandom);
      st_commit_valid  = ($urandom_range(0, 99) < p_st);
      st_commit_addr   = 32'($urandom_range(0, 7));
      st_commit_funct3 = f3s[$urandom_range(0, 2)];
      st_commit_data   = $urandom;
      flush            = ($urandom_range(0, 99) < p_fl);
      #3;
      model_check();
      @(posedge clk);
      model_step();
   endtask

   initial begin
      reset = 1; ld_req_valid = 0; ld_req_addr = '0; ld_req_funct3 = '0; ld_req_tag = '0;
      st_commit_valid = 0; st_commit_addr = '0; st_commit_funct3 = '0; st_commit_data = '0;
      flush = 0;
      @(posedge clk);
      for (int i = 0; i < 2; i++) cycle(50, 50, 0, 0, 100);
      // mixed traffic with frequent address collisions
      for (int i = 0; i < 400; i++) cycle(60, 25, 5, 0, 0);
      // store-heavy: queue fills and forces drains
      for (int i = 0; i < 400; i++) cycle(90, 80, 0, 1, 0);
      // sparse stores under a continuous non-conflicting load stream: starvation
      for (int i = 0; i < 400; i++) cycle(100, 5, 0, 1, 0);
      // heavy flushing
      for (int i = 0; i < 300; i++) cycle(70, 40, 30, 0, 0);
      // occasional reset in the middle of activity
      for (int i = 0; i < 400; i++) cycle(60, 50, 10, 0, 3);
      // quiet tail: queue drains out
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
      chk("forced_drains_seen", 64'(n_forced > 0), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
